cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
Parametrised N-source arbiter and registered multiplexer for the Tomasulo common data bus (CDB). Functional units and load buffers raise requests carrying a result tag and data. The block grants exactly one source per cycle, using round-robin or fixed priority, and broadcasts the winner's tag and data on a registered CDB one cycle later. It replaces the flat combinational select muxes in the writeback path.

Parameters:
NUM_SRC, 4, number of requesting sources (>=2)
DATA_W, 32, result data width
TAG_W, 4, reservation-station tag width
SRC_W, $clog2(NUM_SRC), source index width (derived, not overridden)
CNT_W, 16, width of the conflict statistics counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NUM_SRC  per-source request; held until granted
src_tag  in  NUM_SRC*TAG_W  packed tags; source i at [i*TAG_W +: TAG_W]
src_data  in  NUM_SRC*DATA_W  packed data; source i at [i*DATA_W +: DATA_W]
prio_mode  in  1  0 = round-robin, 1 = fixed priority (lowest index wins)
flush  in  1  synchronous pipeline flush (mispredict / exception)
grant  out  NUM_SRC  one-hot grant, combinational, same cycle as req
cdb_valid  out  1  registered broadcast valid
cdb_tag  out  TAG_W  registered broadcast tag
cdb_data  out  DATA_W  registered broadcast data
cdb_src  out  SRC_W  index of the source that produced the broadcast
conflict_cnt  out  CNT_W  saturating count of cycles with >=2 requests

Behaviour:
- Reset (rst_n low, async): cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, conflict_cnt=0, rr_ptr=0. grant=0 while reset is asserted.
- grant is combinational from req, rr_ptr, prio_mode and flush. It is either all-zero or one-hot, and is never set for a source with req=0.
- A request is consumed at the rising edge where grant[i]=1. The source drops req, or presents its next result, in the following cycle.
- Round-robin (prio_mode=0): search indices rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_SRC. The first requester wins.
- Round-robin pointer update: after a grant to i, rr_ptr <= (i+1) mod NUM_SRC, including the wrap from NUM_SRC-1 to 0. With no grant, rr_ptr holds.
- Fixed priority (prio_mode=1): lowest requesting index wins. rr_ptr holds.
- prio_mode may change on any cycle and takes effect combinationally.
- Fairness: in round-robin mode, a continuously requesting source is granted within NUM_SRC cycles.
- Broadcast latency is 1 cycle. At the edge that consumes grant[i], the block registers cdb_valid<=1, cdb_tag<=src_tag[i], cdb_data<=src_data[i], cdb_src<=i.
- With no grant: cdb_valid<=0. cdb_tag, cdb_data and cdb_src hold their last values and are don't-care while cdb_valid=0.
- The CDB has no back-pressure. Every broadcast lasts exactly one cycle.
- flush=1 forces grant=0. At the next edge: cdb_valid<=0, rr_ptr<=0. Requests are not consumed; sources keep or drop them under their own flush logic.
- flush during a cycle where cdb_valid=1 does not retract the broadcast already on the bus. It only suppresses the next one.
- conflict_cnt increments by 1 at each edge where popcount(req)>=2 and flush=0. It saturates at 2^CNT_W-1 with no wrap. It is cleared only by reset.
- Asynchronous reset asserted mid-broadcast clears cdb_valid immediately. Sources are not considered granted in that cycle.

Decomposition:
- Shared package tomasulo_pkg holds DATA_W, TAG_W, NUM_CDB_SRC and the source-index enumeration (SRC_ADD, SRC_MUL, SRC_DIV, SRC_LOAD) used to bind sources to ports.
- Sub-module rr_pick: purely combinational rotate-and-priority-encode. Inputs: req, ptr, fixed. Outputs: one-hot grant, index, any.
- cdb_arbiter instantiates rr_pick and adds the pointer, flush, output registers, counter and the DATA/TAG select muxes.

Test Plan:
- Reset check: hold rst_n=0 with req=4'b1111 -> grant=0, cdb_valid=0, conflict_cnt=0. Release reset -> grant=4'b0001 in the first active cycle.
- Single source: req=4'b0100, tag=5, data=32'hDEADBEEF for one cycle -> grant=4'b0100. Next cycle: cdb_valid=1, cdb_tag=5, cdb_data=32'hDEADBEEF, cdb_src=2. The cycle after: cdb_valid=0.
- Round-robin with wrap: req=4'b1111 held for 8 cycles, prio_mode=0 -> grants 0,1,2,3,0,1,2,3. conflict_cnt=8.
- Fixed priority: prio_mode=1, req=4'b1010 for 3 cycles -> grant=4'b0010 every cycle. Source 3 is starved; rr_ptr is unchanged.
- Flush: rr_ptr=2, req=4'b1111, flush=1 for one cycle -> grant=0, next cycle cdb_valid=0. Drop flush -> grant=4'b0001.
- Counter saturation with CNT_W=4: req=4'b0011 held for 20 cycles -> conflict_cnt stops at 15.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo writeback constants and the CDB source binding.
package tomasulo_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned TAG_W       = 4;
    localparam int unsigned NUM_CDB_SRC = 4;

    // Binds functional units / load buffers to arbiter request ports.
    typedef enum logic [1:0] {
        SRC_ADD  = 2'd0,
        SRC_MUL  = 2'd1,
        SRC_DIV  = 2'd2,
        SRC_LOAD = 2'd3
    } cdb_src_e;

endpackage : tomasulo_pkg

// File: rtl/rr_pick.sv
// Rotate-and-priority-encode: first requester at or after ptr (or from 0 when fixed).
module rr_pick
    import tomasulo_pkg::*;
#(
    parameter int unsigned NUM_SRC = NUM_CDB_SRC,
    parameter int unsigned SRC_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    input  logic               fixed,
    output logic [NUM_SRC-1:0] grant,
    output logic [SRC_W-1:0]   index,
    output logic               any
);

    int unsigned      base;
    logic [SRC_W-1:0] j;

    // Walk indices base, base+1, ... modulo NUM_SRC; first hit wins.
    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        j     = '0;
        base  = fixed ? 32'd0 : 32'(ptr);
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            j = SRC_W'((base + 32'(k)) % NUM_SRC);
            if (!any && req[j]) begin
                any      = 1'b1;
                index    = j;
                grant[j] = 1'b1;
            end
        end
    end

endmodule : rr_pick

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one grant per cycle, registered one-cycle broadcast.
module cdb_arbiter #(
    parameter int unsigned NUM_SRC = tomasulo_pkg::NUM_CDB_SRC,
    parameter int unsigned DATA_W  = tomasulo_pkg::DATA_W,
    parameter int unsigned TAG_W   = tomasulo_pkg::TAG_W,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned SRC_W  = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        req,
    input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic                      prio_mode,
    input  logic                      flush,
    output logic [NUM_SRC-1:0]        grant,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [SRC_W-1:0]          cdb_src,
    output logic [CNT_W-1:0]          conflict_cnt
);

    import tomasulo_pkg::*;

    logic [SRC_W-1:0]   rr_ptr;
    logic [NUM_SRC-1:0] pick_grant;
    logic [SRC_W-1:0]   pick_idx;
    logic               pick_any;
    logic               take;
    logic [TAG_W-1:0]   sel_tag;
    logic [DATA_W-1:0]  sel_data;
    logic [SRC_W-1:0]   next_ptr;

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .fixed (prio_mode),
        .grant (pick_grant),
        .index (pick_idx),
        .any   (pick_any)
    );

    // Flush and reset both mask the grant; a masked grant consumes nothing.
    assign take     = pick_any && !flush && rst_n;
    assign grant    = take ? pick_grant : '0;
    assign next_ptr = (pick_idx == SRC_W'(NUM_SRC - 1)) ? '0 : pick_idx + SRC_W'(1);

    // One-hot select of the winning source's tag and data.
    always_comb begin
        sel_tag  = '0;
        sel_data = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (pick_grant[i]) begin
                sel_tag  = src_tag[i*TAG_W +: TAG_W];
                sel_data = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Broadcast registers and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_src   <= '0;
            rr_ptr    <= '0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
            rr_ptr    <= '0;
        end else if (take) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= sel_tag;
            cdb_data  <= sel_data;
            cdb_src   <= pick_idx;
            if (!prio_mode) begin
                rr_ptr <= next_ptr;
            end
        end else begin
            cdb_valid <= 1'b0;
        end
    end

    // Saturating count of contended cycles; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (!flush && ($countones(req) >= 2) && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

endmodule : cdb_arbiter

// File: tb/tb_cdb_arbiter.sv
// Directed plus randomized bench for cdb_arbiter against a behavioural model.
module tb_cdb_arbiter;
    import tomasulo_pkg::*;

    localparam int N  = 4;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req;
    logic [N*TAG_W-1:0]  src_tag;
    logic [N*DATA_W-1:0] src_data;
    logic              prio_mode;
    logic              flush;
    logic [N-1:0]      grant;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic [1:0]        cdb_src;
    logic [CW-1:0]     conflict_cnt;

    cdb_arbiter #(
        .NUM_SRC (N),
        .DATA_W  (DATA_W),
        .TAG_W   (TAG_W),
        .CNT_W   (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .src_tag      (src_tag),
        .src_data     (src_data),
        .prio_mode    (prio_mode),
        .flush        (flush),
        .grant        (grant),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .cdb_src      (cdb_src),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int                m_ptr;
    bit                m_valid;
    logic [TAG_W-1:0]  m_tag;
    logic [DATA_W-1:0] m_data;
    int                m_src;
    int                m_cnt;
    int                last_w;
    bit                pend [N];

    function automatic int winner(input logic [N-1:0] r, input int ptr,
                                  input bit fixed, input bit fl);
        if (fl) return -1;
        for (int k = 0; k < N; k++) begin
            int j = fixed ? k : (ptr + k) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_valid = 0; m_tag = '0; m_data = '0; m_src = 0; m_cnt = 0;
    endtask

    // One clock: check grant before the edge, advance model, check registers after.
    task automatic cycle();
        logic [N-1:0] eg;
        int w;
        #1;
        w  = winner(req, m_ptr, prio_mode, flush);
        eg = (w < 0) ? '0 : (N'(1) << w);
        chk("grant", 64'(grant), 64'(eg));
        @(posedge clk);
        if (!flush && $countones(req) >= 2 && m_cnt < CNT_MAX) m_cnt++;
        if (flush) begin
            m_valid = 0;
            m_ptr   = 0;
        end else if (w >= 0) begin
            m_valid = 1;
            m_tag   = src_tag[w*TAG_W +: TAG_W];
            m_data  = src_data[w*DATA_W +: DATA_W];
            m_src   = w;
            if (!prio_mode) m_ptr = (w + 1) % N;
        end else begin
            m_valid = 0;
        end
        last_w = w;
        #1;
        chk("cdb_valid", 64'(cdb_valid), 64'(m_valid));
        if (m_valid) begin
            chk("cdb_tag",  64'(cdb_tag),  64'(m_tag));
            chk("cdb_data", 64'(cdb_data), 64'(m_data));
            chk("cdb_src",  64'(cdb_src),  64'(m_src));
        end
        chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
    endtask

    task automatic rand_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            if ($urandom_range(0, 7) == 0) prio_mode = ~prio_mode;
            flush = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1;
                    src_tag[i*TAG_W +: TAG_W]    = TAG_W'($urandom);
                    src_data[i*DATA_W +: DATA_W] = $urandom;
                end
                req[i] = pend[i];
            end
            cycle();
            if (last_w >= 0) pend[last_w] = 0;
            if (flush) begin
                for (int i = 0; i < N; i++)
                    if ($urandom_range(0, 1) == 1) pend[i] = 0;
            end
        end
    endtask

    initial begin
        // Reset with all sources requesting
        rst_n = 0; req = 4'b1111; prio_mode = 0; flush = 0;
        src_tag = '0; src_data = '0;
        for (int i = 0; i < N; i++) begin
            src_tag[i*TAG_W +: TAG_W]    = TAG_W'(i + 8);
            src_data[i*DATA_W +: DATA_W] = 32'h1000 + 32'(i);
            pend[i] = 0;
        end
        model_reset();
        #12;
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_valid", 64'(cdb_valid), 64'(0));
        chk("rst_cnt", 64'(conflict_cnt), 64'(0));
        @(negedge clk);
        rst_n = 1;
        cycle();
        chk("rst_first_grant", 64'(last_w), 64'(0));

        // Single source
        req = 4'b0100;
        src_tag[SRC_DIV*TAG_W +: TAG_W]    = TAG_W'(5);
        src_data[SRC_DIV*DATA_W +: DATA_W] = 32'hDEADBEEF;
        cycle();
        chk("single_tag", 64'(cdb_tag), 64'(5));
        chk("single_data", 64'(cdb_data), 64'h0DEADBEEF);
        chk("single_src", 64'(cdb_src), 64'(SRC_DIV));
        req = 4'b0000;
        cycle();
        chk("single_drop", 64'(cdb_valid), 64'(0));

        // Pointer back to 0, then round-robin with wrap
        flush = 1; cycle(); flush = 0;
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("rr_order", 64'(last_w), 64'(i % N));
        end

        // Fixed priority: source 1 starves source 3
        prio_mode = 1; req = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("fixed_win", 64'(last_w), 64'(1));
        end
        prio_mode = 0; req = 4'b0001;
        cycle();
        chk("fixed_ptr_held", 64'(last_w), 64'(0));

        // Flush with pointer at 2
        req = 4'b0010; cycle();
        req = 4'b1111; flush = 1;
        cycle();
        chk("flush_grant", 64'(last_w), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("flush_valid", 64'(cdb_valid), 64'(0));
        flush = 0;
        cycle();
        chk("post_flush", 64'(last_w), 64'(0));

        // Counter saturation
        req = 4'b0011;
        for (int i = 0; i < 20; i++) cycle();
        chk("cnt_sat", 64'(conflict_cnt), 64'(CNT_MAX));

        // Randomized traffic
        req = '0;
        rand_cycles(300);

        // Async reset in the middle of a broadcast
        flush = 0; prio_mode = 0; req = 4'b0001;
        cycle();
        chk("pre_async_valid", 64'(cdb_valid), 64'(1));
        #2 rst_n = 0;
        #1;
        chk("async_valid", 64'(cdb_valid), 64'(0));
        chk("async_grant", 64'(grant), 64'(0));
        chk("async_cnt", 64'(conflict_cnt), 64'(0));
        model_reset();
        for (int i = 0; i < N; i++) pend[i] = 0;
        req = '0;
        @(negedge clk);
        rst_n = 1;
        rand_cycles(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cdb_arbiter
